// File: rtl/conv_adder_pkg.sv
// Shared definitions for the conv accumulator adder bank.
//   act_mode_t : output activation selector (3 = reserved, behaves as none)
//   sat_to     : signed saturate of a 64-bit value to an n-bit signed range
//   sat_hit    : 1 when sat_to would clip
//   relu6_max  : 6.0 expressed with frac fractional bits
package conv_adder_pkg;

  typedef enum logic [1:0] {
    ACT_NONE  = 2'd0,
    ACT_RELU  = 2'd1,
    ACT_RELU6 = 2'd2,
    ACT_RSVD  = 2'd3
  } act_mode_t;

  function automatic logic signed [63:0] sat_to(input logic signed [63:0] x,
                                                input int unsigned n);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (n - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (x > hi)      sat_to = hi;
    else if (x < lo) sat_to = lo;
    else             sat_to = x;
  endfunction

  function automatic logic sat_hit(input logic signed [63:0] x,
                                   input int unsigned n);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (n - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    sat_hit = (x > hi) || (x < lo);
  endfunction

  function automatic logic signed [63:0] relu6_max(input int unsigned frac);
    relu6_max = 64'sd6 <<< frac;
  endfunction

endpackage

// File: rtl/pipelined_adder_tree.sv
// Registered pairwise adder tree reducing NUM_INPUTS signed products to one sum.
//   clk, rst : clock, async active-high reset
//   data_in  : NUM_INPUTS x DATA_W signed products, input k at [k*DATA_W +: DATA_W]
//   sum      : full-precision sum, valid $clog2(NUM_INPUTS) cycles after data_in
module pipelined_adder_tree #(
  parameter int unsigned DATA_W     = 14,
  parameter int unsigned NUM_INPUTS = 27
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [DATA_W*NUM_INPUTS-1:0]                data_in,
  output logic signed [DATA_W+$clog2(NUM_INPUTS)-1:0] sum
);

  localparam int unsigned LEVELS = $clog2(NUM_INPUTS);
  localparam int unsigned SUM_W  = DATA_W + LEVELS;
  localparam int unsigned PAD    = 1 << LEVELS;

  // Leaves are padded to a power of two with zeros, so an odd operand at any
  // level is simply added to zero and passes through unchanged.
  logic signed [SUM_W-1:0] leaf [PAD];

  for (genvar i = 0; i < PAD; i++) begin : g_leaf
    if (i < NUM_INPUTS) begin : g_real
      assign leaf[i] = SUM_W'(signed'(data_in[i*DATA_W +: DATA_W]));
    end else begin : g_zero
      assign leaf[i] = '0;
    end
  end

  for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
    localparam int unsigned N = PAD >> l;
    logic signed [SUM_W-1:0] prev [2*N];
    logic signed [SUM_W-1:0] s    [N];

    if (l == 1) begin : g_src_leaf
      assign prev = leaf;
    end else begin : g_src_lvl
      assign prev = g_lvl[l-1].s;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s <= '{default: '0};
      end else begin
        for (int unsigned i = 0; i < N; i++) begin
          s[i] <= prev[2*i] + prev[2*i+1];
        end
      end
    end
  end

  assign sum = g_lvl[LEVELS].s[0];

endmodule

// File: rtl/conv2d_accum_adder.sv
// NUM_CH parallel adder trees, multi-pass accumulation, bias add, activation and
// output saturation for conv/pointwise layers.
//   clk, rst          : clock, async active-high reset
//   valid_in          : beat valid; first_pass / last_pass / act_mode / bias qualified by it
//   data_in           : channel c input k at [(c*NUM_INPUTS+k)*DATA_W +: DATA_W]
//   bias              : channel c at [c*BIAS_W +: BIAS_W], used on the last_pass beat
//   data_out          : channel c at [c*OUT_W +: OUT_W], held between valid_out pulses
//   valid_out         : one-cycle pulse per completed accumulation
//   sat_flag          : sticky accumulator/output saturation indicator
//   busy              : beat in flight or accumulation open
module conv2d_accum_adder
  import conv_adder_pkg::*;
#(
  parameter int unsigned DATA_W     = 14,
  parameter int unsigned FRAC_BITS  = 7,
  parameter int unsigned NUM_INPUTS = 27,
  parameter int unsigned NUM_CH     = 16,
  parameter int unsigned BIAS_W     = 14,
  parameter int unsigned ACC_W      = 24,
  parameter int unsigned OUT_W      = 19
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                valid_in,
  input  logic                                first_pass,
  input  logic                                last_pass,
  input  logic [1:0]                          act_mode,
  input  logic [DATA_W*NUM_INPUTS*NUM_CH-1:0] data_in,
  input  logic [BIAS_W*NUM_CH-1:0]            bias,
  output logic [OUT_W*NUM_CH-1:0]             data_out,
  output logic                                valid_out,
  output logic                                sat_flag,
  output logic                                busy
);

  localparam int unsigned LEVELS = $clog2(NUM_INPUTS);
  localparam int unsigned SUM_W  = DATA_W + LEVELS;

  // Sideband pipe, aligned with the tree levels
  logic [LEVELS-1:0]        v_pipe, f_pipe, l_pipe;
  act_mode_t                m_pipe [LEVELS];
  logic [BIAS_W*NUM_CH-1:0] b_pipe [LEVELS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_pipe <= '0;
      f_pipe <= '0;
      l_pipe <= '0;
      m_pipe <= '{default: ACT_NONE};
      b_pipe <= '{default: '0};
    end else begin
      v_pipe[0] <= valid_in;
      f_pipe[0] <= first_pass;
      l_pipe[0] <= last_pass;
      m_pipe[0] <= act_mode_t'(act_mode);
      b_pipe[0] <= bias;
      for (int unsigned s = 1; s < LEVELS; s++) begin
        v_pipe[s] <= v_pipe[s-1];
        f_pipe[s] <= f_pipe[s-1];
        l_pipe[s] <= l_pipe[s-1];
        m_pipe[s] <= m_pipe[s-1];
        b_pipe[s] <= b_pipe[s-1];
      end
    end
  end

  logic signed [SUM_W-1:0] tree_sum [NUM_CH];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    pipelined_adder_tree #(
      .DATA_W     (DATA_W),
      .NUM_INPUTS (NUM_INPUTS)
    ) u_tree (
      .clk     (clk),
      .rst     (rst),
      .data_in (data_in[c*NUM_INPUTS*DATA_W +: NUM_INPUTS*DATA_W]),
      .sum     (tree_sum[c])
    );
  end

  // Accumulate stage
  logic signed [ACC_W-1:0]  acc      [NUM_CH];
  logic signed [ACC_W-1:0]  acc_nxt  [NUM_CH];
  logic signed [63:0]       acc_wide [NUM_CH];
  logic                     acc_ovf;
  logic                     v_a, l_a;
  act_mode_t                m_a;
  logic [BIAS_W*NUM_CH-1:0] b_a;

  always_comb begin
    acc_ovf = 1'b0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      acc_wide[c] = f_pipe[LEVELS-1] ? 64'(tree_sum[c])
                                     : 64'(acc[c]) + 64'(tree_sum[c]);
      acc_nxt[c]  = ACC_W'(sat_to(acc_wide[c], ACC_W));
      acc_ovf     = acc_ovf | sat_hit(acc_wide[c], ACC_W);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '{default: '0};
      v_a <= 1'b0;
      l_a <= 1'b0;
      m_a <= ACT_NONE;
      b_a <= '0;
    end else begin
      v_a <= v_pipe[LEVELS-1];
      l_a <= l_pipe[LEVELS-1];
      m_a <= m_pipe[LEVELS-1];
      b_a <= b_pipe[LEVELS-1];
      if (v_pipe[LEVELS-1]) acc <= acc_nxt;
    end
  end

  // Bias, activation, output saturation
  logic signed [63:0] y_wide  [NUM_CH];
  logic [OUT_W-1:0]   out_nxt [NUM_CH];
  logic               out_ovf;

  always_comb begin
    out_ovf = 1'b0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      y_wide[c] = 64'(acc[c]) + 64'(signed'(b_a[c*BIAS_W +: BIAS_W]));
      case (m_a)
        ACT_RELU:  if (y_wide[c] < 0) y_wide[c] = '0;
        ACT_RELU6: begin
          if (y_wide[c] < 0)                           y_wide[c] = '0;
          else if (y_wide[c] > relu6_max(FRAC_BITS))   y_wide[c] = relu6_max(FRAC_BITS);
        end
        default: ;
      endcase
      out_nxt[c] = OUT_W'(sat_to(y_wide[c], OUT_W));
      out_ovf    = out_ovf | sat_hit(y_wide[c], OUT_W);
    end
  end

  logic acc_open;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out  <= '0;
      valid_out <= 1'b0;
      sat_flag  <= 1'b0;
      acc_open  <= 1'b0;
    end else begin
      valid_out <= v_a & l_a;
      if (v_a & l_a) begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
          data_out[c*OUT_W +: OUT_W] <= out_nxt[c];
        end
      end
      sat_flag <= sat_flag | (v_pipe[LEVELS-1] & acc_ovf) | (v_a & l_a & out_ovf);
      if (valid_in) begin
        if (first_pass)     acc_open <= ~last_pass;
        else if (last_pass) acc_open <= 1'b0;
      end
    end
  end

  assign busy = (|v_pipe) | v_a | acc_open;

endmodule
